// File: rtl/sync_seq_pkg.sv
// Shared encoding for the sequencer: one-hot state bits over [4:1], IDLE is all-zero.
package sync_seq_pkg;

  localparam int ST_ARM  = 1;
  localparam int ST_SYNC = 2;
  localparam int ST_GATE = 3;
  localparam int ST_DONE = 4;

  typedef logic [4:1] state_vec_t;

  localparam state_vec_t IDLE   = 4'b0000;
  localparam state_vec_t S_ARM  = 4'b0001;
  localparam state_vec_t S_SYNC = 4'b0010;
  localparam state_vec_t S_GATE = 4'b0100;
  localparam state_vec_t S_DONE = 4'b1000;

endpackage

// File: rtl/sync_seq_ctrl_wait_cnt.sv
// Loadable down-counter with nonzero flag; clr beats load beats decrement.
module wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         nz
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: clear, load, or step toward zero without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)               cnt_d = '0;
    else if (load)         cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign nz  = |cnt_q;

endmodule

// File: rtl/sync_seq_ctrl.sv
// Sequencer FSM (IDLE/ARM/SYNC/GATE/DONE) with dwell timer and restart cooldown.
// All outputs come straight from registers so the downstream decode sees
// glitch-free prev_state / wc0.
module sync_seq_ctrl
  import sync_seq_pkg::*;
#(
  parameter int WC_W     = 8,
  parameter int ARM_CYC  = 16,
  parameter int GATE_CYC = 32,
  parameter int COOL_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sync_ack,
  output logic [4:1]       prev_state,
  output logic             wc0,
  output logic [CNT_W-1:0] seq_cnt,
  output logic             busy
);

  state_vec_t       state_d, state_q;
  logic [CNT_W-1:0] seq_cnt_d, seq_cnt_q;
  logic             cnt_load, cnt_clr, cnt_nz;
  logic [WC_W-1:0]  cnt_load_val, cnt_val;

  wait_cnt #(.W(WC_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .clr      (cnt_clr),
    .cnt      (cnt_val),
    .nz       (cnt_nz)
  );

  // Next-state / counter control; abort wins over everything, and in IDLE it
  // simply kills any pending cooldown.
  always_comb begin
    state_d      = state_q;
    seq_cnt_d    = seq_cnt_q;
    cnt_load     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load_val = '0;
    if (abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // Start during cooldown is dropped, not queued.
          if (start && !cnt_nz) begin
            state_d      = S_ARM;
            cnt_load     = 1'b1;
            cnt_load_val = WC_W'(ARM_CYC);
          end
        end
        S_ARM: begin
          // Leave on the 1->0 edge; <=1 keeps a zero count from stalling here.
          if (cnt_val <= WC_W'(1)) state_d = S_SYNC;
        end
        S_SYNC: begin
          if (sync_ack) begin
            state_d      = S_GATE;
            cnt_load     = 1'b1;
            cnt_load_val = WC_W'(GATE_CYC);
          end
        end
        S_GATE: begin
          if (cnt_val <= WC_W'(1)) state_d = S_DONE;
        end
        S_DONE: begin
          state_d      = IDLE;
          cnt_load     = 1'b1;
          cnt_load_val = WC_W'(COOL_CYC);
          if (seq_cnt_q != '1) seq_cnt_d = seq_cnt_q + 1'b1;
        end
        default: begin
          // Not one-hot: recover to IDLE with a clean counter.
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // State and completed-sequence registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seq_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign prev_state = state_q;
  assign wc0        = cnt_nz;
  assign seq_cnt    = seq_cnt_q;
  assign busy       = |state_q;

endmodule

// File: doc/sync_seq_ctrl.md
Name: sync_seq_ctrl

Overview:
- Sequencer FSM plus wait counter; sits directly upstream of the Sync/Gate/Done output decode stage.
- Produces the registered state vector prev_state[4:1] and the wait-counter-busy flag wc0 that the decode stage consumes.
- The decode stage asserts Sync only when prev_state is all-zero and wc0=0, so this block owns state encoding, dwell timing and restart cooldown.

Parameters:
- WC_W, 8, width of wait counter
- ARM_CYC, 16, ARM dwell cycles (1..2^WC_W-1)
- GATE_CYC, 32, GATE dwell cycles (1..2^WC_W-1)
- COOL_CYC, 4, post-DONE cooldown cycles during which wc0 stays high (0 allowed)
- CNT_W, 8, width of completed-sequence counter

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  request new sequence (level, sampled in IDLE)
- abort  input  1  cancel sequence from any state
- sync_ack  input  1  downstream acknowledge of SYNC phase
- prev_state  output  4 [4:1]  state vector: bit1=ARM, bit2=SYNC, bit3=GATE, bit4=DONE, all-zero=IDLE
- wc0  output  1  registered, 1 when wait counter != 0
- seq_cnt  output  CNT_W  completed sequences, saturating
- busy  output  1  prev_state != 0

Behaviour:
- Reset (async, rst_n=0): prev_state=4'b0000, counter=0, wc0=0, seq_cnt=0, busy=0. Deassertion is synchronised by the integrator; the block has no internal synchroniser.
- All outputs are registered; no combinational input-to-output path.
- Encoding: exactly one-hot or all-zero at all times. Any other value is illegal and returns to IDLE on the next edge.
- Counter: loaded on the state-entry edge; decrements by 1 each cycle while nonzero; never wraps below 0. wc0 reflects the counter register.
- IDLE:
  - start=1 and wc0=0 -> ARM; load ARM_CYC.
  - start during cooldown (wc0=1) is ignored; it is not queued.
- ARM:
  - Advances to SYNC on the edge where the counter goes 1->0, i.e. ARM_CYC cycles in ARM.
- SYNC:
  - Holds until sync_ack=1, then goes to GATE and loads GATE_CYC.
  - No timeout.
- GATE:
  - Dwells GATE_CYC cycles, then DONE.
- DONE:
  - Exactly 1 cycle, then IDLE.
  - Loads COOL_CYC on the DONE->IDLE edge.
  - seq_cnt increments on that edge; saturates at all-ones.
- abort=1 in any non-IDLE state:
  - Next state IDLE; counter cleared to 0 (no cooldown); seq_cnt unchanged.
  - abort has priority over every other transition, including sync_ack and counter expiry on the same cycle.
- abort in IDLE: clears any cooldown counter.
- start held continuously: a new sequence begins on the first IDLE cycle with wc0=0.
- Reset mid-sequence: immediate return to reset values; seq_cnt cleared.

Decomposition:
- Shared package sync_seq_pkg:
  - state bit index constants ST_ARM=1, ST_SYNC=2, ST_GATE=3, ST_DONE=4
  - typedef state_vec_t [4:1]
  - IDLE constant 4'b0000
- One natural sub-module: wait_cnt, a loadable down-counter with a nonzero flag (ports load, load_val, clr, cnt, nz).
- FSM and seq_cnt live in the top.

Test Plan:
- Reset then idle 5 cycles -> prev_state=0000, wc0=0, seq_cnt=0 throughout.
- start pulse, sync_ack tied 1, defaults -> ARM for 16 cycles, SYNC 1 cycle, GATE 32 cycles, DONE 1 cycle, then wc0=1 for 4 cycles; seq_cnt=1.
- start held high across completion -> next ARM entry occurs exactly on the first cycle wc0=0 after the 4-cycle cooldown.
- abort asserted on GATE cycle 10 together with counter activity -> next cycle prev_state=0000, wc0=0, seq_cnt unchanged; start on the following cycle enters ARM.
- sync_ack held 0 for 100 cycles in SYNC, then pulsed -> prev_state stays 0010, then 0100 with counter=32. Same-cycle abort+sync_ack -> IDLE.
- CNT_W=2, run 5 sequences -> seq_cnt saturates at 3. Assert rst_n low mid-ARM -> all outputs zero asynchronously, before the next clock edge.
